// File: rtl/rst_seq_if.sv
// Sequencer-facing bundle for rst_seq_ctrl: delay config, warm-reset handshake and stage resets.
// RST_SEQ_CLKEN_EN adds the per-stage clock-enable vector.
interface rst_seq_if #(
  parameter int NUM_STG = 4,
  parameter int DLY_W   = 8
);
  localparam int CW = $clog2(NUM_STG);

  logic [NUM_STG*DLY_W-1:0] stg_dly;
  logic                     sw_rst_req;
  logic                     sw_rst_ack;
  logic [NUM_STG-1:0]       stg_rst_n;
  logic                     seq_busy;
  logic                     seq_done;
  logic [CW-1:0]            cur_stg;
`ifdef RST_SEQ_CLKEN_EN
  logic [NUM_STG-1:0]       stg_clk_en;

  modport master (
    output stg_dly, sw_rst_req,
    input  sw_rst_ack, stg_rst_n, seq_busy, seq_done, cur_stg, stg_clk_en
  );
  modport slave (
    input  stg_dly, sw_rst_req,
    output sw_rst_ack, stg_rst_n, seq_busy, seq_done, cur_stg, stg_clk_en
  );
`else
  modport master (
    output stg_dly, sw_rst_req,
    input  sw_rst_ack, stg_rst_n, seq_busy, seq_done, cur_stg
  );
  modport slave (
    input  stg_dly, sw_rst_req,
    output sw_rst_ack, stg_rst_n, seq_busy, seq_done, cur_stg
  );
`endif
endinterface

// File: rtl/rst_seq_ctrl.sv
// rst_seq_ctrl: ordered stage-reset release with per-stage delay and warm-reset re-assert.
// Optional RST_SEQ_CLKEN_EN: per-stage clock enables that lead each reset release.
//   state  | meaning
//   HOLD   | all stages in reset, hold timer running
//   REL    | stage cur_stg counting down its delay, then released
//   DONE   | all stages released, waiting for sw_rst_req
//   ASSERT | re-asserting one stage per cycle, highest index first
module rst_seq_ctrl #(
  parameter int NUM_STG  = 4,
  parameter int DLY_W    = 8,
  parameter int HOLD_CYC = 16
) (
  input logic      aclk_i,
  input logic      arst_n_i,
  rst_seq_if.slave bus
);
  localparam int CW = $clog2(NUM_STG);
  localparam int IW = CW + 1;
  localparam int HW = $clog2(HOLD_CYC + 1);

  typedef enum logic [1:0] {
    S_HOLD   = 2'd0,
    S_REL    = 2'd1,
    S_DONE   = 2'd2,
    S_ASSERT = 2'd3
  } state_e;

  state_e             state_q;
  logic [HW-1:0]      hold_cnt_q;
  logic [DLY_W-1:0]   dly_cnt_q;
  logic [CW-1:0]      cur_stg_q;
  logic [NUM_STG-1:0] rst_n_q;
  logic               ack_q;
  logic               busy_q;
  logic               done_q;
`ifdef RST_SEQ_CLKEN_EN
  logic [NUM_STG-1:0] clk_en_q;
`endif

  logic [IW-1:0]      nxt_idx_d;
  logic [DLY_W-1:0]   nxt_dly_d;
  logic               last_stg_d;

  // Delay field of the stage that follows cur_stg; sampled only when that stage is entered.
  always_comb begin
    nxt_idx_d  = {1'b0, cur_stg_q} + IW'(1);
    last_stg_d = (cur_stg_q == CW'(NUM_STG - 1));
    nxt_dly_d  = '0;
    for (int i = 0; i < NUM_STG; i++) begin
      if (nxt_idx_d == IW'(i)) nxt_dly_d = bus.stg_dly[i*DLY_W +: DLY_W];
    end
  end

  always_ff @(posedge aclk_i) begin
    if (!arst_n_i) begin
      state_q    <= S_HOLD;
      hold_cnt_q <= '0;
      dly_cnt_q  <= '0;
      cur_stg_q  <= '0;
      rst_n_q    <= '0;
      ack_q      <= 1'b0;
      busy_q     <= 1'b1;
      done_q     <= 1'b0;
`ifdef RST_SEQ_CLKEN_EN
      clk_en_q   <= '0;
`endif
    end else begin
      ack_q <= 1'b0;
      case (state_q)
        S_HOLD: begin
          if (hold_cnt_q == HW'(HOLD_CYC - 1)) begin
            hold_cnt_q <= '0;
            state_q    <= S_REL;
            cur_stg_q  <= '0;
            dly_cnt_q  <= bus.stg_dly[DLY_W-1:0];
`ifdef RST_SEQ_CLKEN_EN
            clk_en_q[0] <= 1'b1;
`endif
          end else begin
            hold_cnt_q <= hold_cnt_q + 1'b1;
          end
        end
        S_REL: begin
          if (dly_cnt_q != '0) begin
            dly_cnt_q <= dly_cnt_q - 1'b1;
          end else begin
            rst_n_q[cur_stg_q] <= 1'b1;
            if (last_stg_d) begin
              state_q   <= S_DONE;
              cur_stg_q <= '0;
              dly_cnt_q <= '0;
              done_q    <= 1'b1;
              busy_q    <= 1'b0;
            end else begin
              cur_stg_q <= nxt_idx_d[CW-1:0];
              dly_cnt_q <= nxt_dly_d;
`ifdef RST_SEQ_CLKEN_EN
              clk_en_q[nxt_idx_d[CW-1:0]] <= 1'b1;
`endif
            end
          end
        end
        S_DONE: begin
          if (bus.sw_rst_req) begin
            state_q   <= S_ASSERT;
            cur_stg_q <= CW'(NUM_STG - 1);
            done_q    <= 1'b0;
            busy_q    <= 1'b1;
          end
        end
        S_ASSERT: begin
          rst_n_q[cur_stg_q] <= 1'b0;
`ifdef RST_SEQ_CLKEN_EN
          clk_en_q[cur_stg_q] <= 1'b0;
`endif
          if (cur_stg_q == '0) begin
            ack_q      <= 1'b1;
            state_q    <= S_HOLD;
            hold_cnt_q <= '0;
          end else begin
            cur_stg_q <= cur_stg_q - 1'b1;
          end
        end
        default: state_q <= S_HOLD;
      endcase
    end
  end

  assign bus.stg_rst_n  = rst_n_q;
  assign bus.sw_rst_ack = ack_q;
  assign bus.seq_busy   = busy_q;
  assign bus.seq_done   = done_q;
  assign bus.cur_stg    = cur_stg_q;
`ifdef RST_SEQ_CLKEN_EN
  assign bus.stg_clk_en = clk_en_q;
`endif

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Self-checking bench for rst_seq_ctrl: timestamp-based reference model plus directed timing pins.
module tb_rst_seq_ctrl;
  localparam int NUM_STG  = 4;
  localparam int DLY_W    = 8;
  localparam int HOLD_CYC = 16;

  logic aclk = 1'b0;
  logic arst_n = 1'b0;

  rst_seq_if #(.NUM_STG(NUM_STG), .DLY_W(DLY_W)) bus ();

  rst_seq_ctrl #(.NUM_STG(NUM_STG), .DLY_W(DLY_W), .HOLD_CYC(HOLD_CYC)) dut (
    .aclk_i  (aclk),
    .arst_n_i(arst_n),
    .bus     (bus.slave)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: time-stamped schedule of hold end and per-stage release edges.
  typedef enum int {M_HOLD, M_REL, M_DONE, M_ASSERT} mode_e;
  mode_e              mode = M_HOLD;
  int                 n = -1;
  int                 k = 0;
  int                 hold_end = 0;
  int                 rel_at = 0;
  int                 m_cur = 0;
  bit                 m_ack = 0;
  logic [NUM_STG-1:0] m_ce = '0;

  int                 e0 = 0;
  int                 ack_edge = 0;
  int                 done_rise = 0;
  int                 rise_rst [NUM_STG];
  int                 fall_rst [NUM_STG];
  int                 rise_ce  [NUM_STG];
  int                 fall_ce  [NUM_STG];
  logic               prev_rst = 1'b0;
  logic [NUM_STG-1:0] prev_rn = '0;
  logic [NUM_STG-1:0] prev_ce = '0;
  logic               prev_done = 1'b0;

  function automatic int fld(input logic [NUM_STG*DLY_W-1:0] d, input int idx);
    return int'(d[idx*DLY_W +: DLY_W]);
  endfunction

  always @(posedge aclk) begin : model_cmp
    logic                     rst_s;
    logic                     req_s;
    logic [NUM_STG*DLY_W-1:0] dly_s;
    logic [NUM_STG-1:0]       exp_rn;
    rst_s = arst_n;
    req_s = bus.sw_rst_req;
    dly_s = bus.stg_dly;
    n++;
    m_ack = 0;
    if (!rst_s) begin
      mode = M_HOLD; k = 0; m_cur = 0; m_ce = '0; hold_end = n + HOLD_CYC;
    end else begin
      case (mode)
        M_HOLD: if (n == hold_end) begin
          mode = M_REL; m_cur = 0; rel_at = n + fld(dly_s, 0) + 1; m_ce = 1;
        end
        M_REL: if (n == rel_at) begin
          k++;
          if (k == NUM_STG) begin
            mode = M_DONE; m_cur = 0;
          end else begin
            m_cur = k; rel_at = n + fld(dly_s, k) + 1; m_ce = NUM_STG'((1 << (k + 1)) - 1);
          end
        end
        M_DONE: if (req_s) begin
          mode = M_ASSERT; m_cur = NUM_STG - 1;
        end
        M_ASSERT: begin
          k--;
          m_ce = NUM_STG'((1 << k) - 1);
          if (k == 0) begin
            m_ack = 1; mode = M_HOLD; hold_end = n + HOLD_CYC; m_cur = 0;
          end else begin
            m_cur = k - 1;
          end
        end
        default: mode = M_HOLD;
      endcase
    end
    if (rst_s && !prev_rst) e0 = n;
    prev_rst = rst_s;
    exp_rn = NUM_STG'((1 << k) - 1);
    #1;
    chk("stg_rst_n", 32'(bus.stg_rst_n), 32'(exp_rn));
    chk("sw_rst_ack", 32'(bus.sw_rst_ack), 32'(m_ack));
    chk("seq_busy", 32'(bus.seq_busy), 32'(mode != M_DONE));
    chk("seq_done", 32'(bus.seq_done), 32'(mode == M_DONE));
    chk("cur_stg", 32'(bus.cur_stg), 32'(m_cur));
`ifdef RST_SEQ_CLKEN_EN
    chk("stg_clk_en", 32'(bus.stg_clk_en), 32'(m_ce));
    chk("clk_en_invariant", 32'(bus.stg_rst_n & ~bus.stg_clk_en), 32'(0));
    for (int i = 0; i < NUM_STG; i++) begin
      if (bus.stg_clk_en[i] && !prev_ce[i]) rise_ce[i] = n;
      if (!bus.stg_clk_en[i] && prev_ce[i]) fall_ce[i] = n;
    end
    prev_ce = bus.stg_clk_en;
`endif
    for (int i = 0; i < NUM_STG; i++) begin
      if (bus.stg_rst_n[i] && !prev_rn[i]) rise_rst[i] = n;
      if (!bus.stg_rst_n[i] && prev_rn[i]) fall_rst[i] = n;
    end
    prev_rn = bus.stg_rst_n;
    if (bus.sw_rst_ack === 1'b1) ack_edge = n;
    if (bus.seq_done === 1'b1 && !prev_done) done_rise = n;
    prev_done = bus.seq_done;
  end

  task automatic set_dly(input int d0, input int d1, input int d2, input int d3);
    bus.stg_dly = {8'(d3), 8'(d2), 8'(d1), 8'(d0)};
  endtask

  task automatic do_reset(input int cyc);
    @(negedge aclk);
    arst_n = 1'b0;
    repeat (cyc) @(negedge aclk);
    arst_n = 1'b1;
  endtask

  task automatic wait_done(input int budget);
    int t = 0;
    while (bus.seq_done !== 1'b1 && t < budget) begin
      @(posedge aclk);
      #2;
      t++;
    end
    if (t >= budget) begin
      checks++;
      errors++;
      $display("FAIL wait_done: timeout after %0d cycles, expected seq_done", t);
    end
  endtask

  task automatic chk_rel(input string nm, input int base, input int o0, input int o1,
                         input int o2, input int o3);
    chk({nm, "_stg0"}, 32'(rise_rst[0] - base), 32'(o0));
    chk({nm, "_stg1"}, 32'(rise_rst[1] - base), 32'(o1));
    chk({nm, "_stg2"}, 32'(rise_rst[2] - base), 32'(o2));
    chk({nm, "_stg3"}, 32'(rise_rst[3] - base), 32'(o3));
  endtask

  initial begin
    logic [3:0] steps [4];
    int dones;
    int acks;
    int t;
    steps = '{4'b0111, 4'b0011, 4'b0001, 4'b0000};
    bus.sw_rst_req = 1'b0;
    set_dly(2, 0, 5, 1);

    // Release timing: rises 19/20/26/28 cycles counting the first high cycle as 1.
    do_reset(3);
    wait_done(200);
    chk_rel("t1_rel", e0, 18, 19, 25, 27);
    chk("t1_done_rise", 32'(done_rise - e0), 32'd27);
    chk("t1_cur_stg", 32'(bus.cur_stg), 32'd0);
`ifdef RST_SEQ_CLKEN_EN
    chk("t6_ce_lead", 32'(rise_rst[0] - rise_ce[0]), 32'd3);
`endif

    // Warm reset: one-cycle request, reverse-order assert, then a full re-release.
    @(negedge aclk);
    bus.sw_rst_req = 1'b1;
    @(posedge aclk);
    #2;
    chk("t2_enter", 32'(bus.stg_rst_n), 32'hF);
    @(negedge aclk);
    bus.sw_rst_req = 1'b0;
    for (int j = 0; j < 4; j++) begin
      @(posedge aclk);
      #2;
      chk("t2_step", 32'(bus.stg_rst_n), 32'(steps[j]));
      chk("t2_ack", 32'(bus.sw_rst_ack), 32'(j == 3));
    end
    wait_done(200);
    chk_rel("t2_rel", ack_edge + 1, 18, 19, 25, 27);
`ifdef RST_SEQ_CLKEN_EN
    for (int i = 0; i < NUM_STG; i++) chk("t6_fall_same_edge", 32'(fall_ce[i]), 32'(fall_rst[i]));
`endif

    // Request held high: exactly one DONE cycle per pass.
    set_dly($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
    bus.sw_rst_req = 1'b1;
    do_reset(2);
    dones = 0;
    acks = 0;
    t = 0;
    while (acks < 3 && t < 600) begin
      @(posedge aclk);
      #2;
      t++;
      if (bus.seq_done === 1'b1) dones++;
      if (bus.sw_rst_ack === 1'b1) acks++;
    end
    chk("t3_acks", 32'(acks), 32'd3);
    chk("t3_dones", 32'(dones), 32'd3);
    bus.sw_rst_req = 1'b0;

    // Reset dropped while stage 2 is mid-delay.
    set_dly(2, 0, 5, 1);
    do_reset(1);
    t = 0;
    while (bus.cur_stg !== 2'd2 && t < 100) begin
      @(posedge aclk);
      #2;
      t++;
    end
    chk("t4_reach_stg2", 32'(bus.cur_stg), 32'd2);
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    arst_n = 1'b0;
    @(posedge aclk);
    #2;
    chk("t4_rst_n", 32'(bus.stg_rst_n), 32'd0);
    chk("t4_busy", 32'(bus.seq_busy), 32'd1);
    chk("t4_ack", 32'(bus.sw_rst_ack), 32'd0);
    chk("t4_cur", 32'(bus.cur_stg), 32'd0);
    @(negedge aclk);
    arst_n = 1'b1;
    wait_done(200);
    chk_rel("t4_rel", e0, 18, 19, 25, 27);

    // Delay extremes: all zero, then all ones.
    set_dly(0, 0, 0, 0);
    do_reset(1);
    wait_done(200);
    chk_rel("t5_zero", e0, 16, 17, 18, 19);
    set_dly(255, 255, 255, 255);
    do_reset(1);
    wait_done(1200);
    chk_rel("t5_max", e0, 271, 527, 783, 1039);

    // Randomized traffic: delay changes at any time, request toggles, sporadic resets.
    for (int c = 0; c < 3000; c++) begin
      @(negedge aclk);
      if ($urandom_range(0, 7) == 0)
        bus.stg_dly[$urandom_range(0, NUM_STG - 1)*DLY_W +: DLY_W] = 8'($urandom_range(0, 6));
      if ($urandom_range(0, 15) == 0) bus.sw_rst_req = ~bus.sw_rst_req;
      arst_n = ($urandom_range(0, 299) != 0);
    end
    @(negedge aclk);
    arst_n = 1'b1;
    repeat (2) @(posedge aclk);
    #3;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
